dither_ctrl: RTL and testbench

DITHER_CTRL -- requirements
Module: dither_ctrl

---
 rtl/dither_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dither_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_ctrl.sv
// Dither request controller.
// Serves two channels, round-robin, with zero, single-step (RPDF) or
// two-step (TPDF) dither drawn from an external +/-1 sequence generator.
// Before serving generated dither, the controller resets the generator and
// then warms it up for 32 steps.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   OFF    | dither disabled; requests answered with 0
//   RSTGEN | one-cycle reset pulse to the generator
//   WARMUP | 32 free-running generator steps (down-counter 31..0)
//   IDLE   | warmed up; waiting for a request
//   STEP1  | first generator step; the RPDF value is taken here
//   STEP2  | second generator step (TPDF only); the sum is formed here
//   DONE   | one-cycle ack with the dither value
module dither_ctrl (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [1:0]        req,
   output logic [1:0]        ack,
   output logic signed [2:0] dither_out,
   output logic              gen_clk_en,
   output logic              gen_rstn,
   input  logic [1:0]        gen_dither,
   output logic              busy
);

   typedef enum logic [2:0] {
      OFF    = 3'd0,
      RSTGEN = 3'd1,
      WARMUP = 3'd2,
      IDLE   = 3'd3,
      STEP1  = 3'd4,
      STEP2  = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [1:0] MODE_ZERO = 2'b00;
   localparam logic [1:0] MODE_TPDF = 2'b10;

   state_t            state_q;
   state_t            state_nxt;
   logic              warm_q;
   logic              last_q;
   logic [4:0]        cnt_q;
   logic [1:0]        mode_q;
   logic [1:0]        gnt_q;
   logic signed [2:0] s1_q;

   logic              grant;
   logic              pick_ch1;
   logic [1:0]        gnt_oh;
   logic signed [2:0] gen_val;
   logic signed [2:0] load_val;
   logic              set_warm;
   logic              clr_warm;
   logic              cnt_load;
   logic              cnt_dec;
   logic              mode_ld;
   logic              latch_s1;

   // ch1 wins if it is alone, or on a tie when ch0 was granted last
   assign pick_ch1 = req[1] & (~req[0] | ~last_q);

   // a fresh grant goes straight to DONE from OFF/IDLE, so the ack uses
   // the new winner; later steps reuse the stored grant
   assign gnt_oh   = grant ? {pick_ch1, ~pick_ch1} : gnt_q;

   assign gen_val  = {gen_dither[1], gen_dither};

   assign busy     = (state_q != OFF) && (state_q != IDLE);

   // next-state and per-state control strobes
   always_comb begin
      state_nxt = state_q;
      grant     = 1'b0;
      load_val  = 3'sd0;
      set_warm  = 1'b0;
      clr_warm  = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      mode_ld   = 1'b0;
      latch_s1  = 1'b0;
      unique case (state_q)
         OFF: begin
            if (en) begin
               state_nxt = RSTGEN;
            end else if (|req) begin
               grant     = 1'b1;
               load_val  = 3'sd0;
               state_nxt = DONE;
            end
         end
         RSTGEN: begin
            cnt_load  = 1'b1;
            state_nxt = WARMUP;
         end
         WARMUP: begin
            if (cnt_q == 5'd0) begin
               set_warm  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_dec   = 1'b1;
            end
         end
         IDLE: begin
            if (!en) begin
               clr_warm  = 1'b1;
               state_nxt = OFF;
            end else if (|req) begin
               grant     = 1'b1;
               mode_ld   = 1'b1;
               if (mode == MODE_ZERO) begin
                  load_val  = 3'sd0;
                  state_nxt = DONE;
               end else begin
                  state_nxt = STEP1;
               end
            end
         end
         STEP1: begin
            if (mode_q == MODE_TPDF) begin
               latch_s1  = 1'b1;
               state_nxt = STEP2;
            end else begin
               load_val  = gen_val;
               state_nxt = DONE;
            end
         end
         STEP2: begin
            load_val  = s1_q + gen_val;
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = warm_q ? IDLE : OFF;
         end
         default: begin
            state_nxt = OFF;
         end
      endcase
   end

   // state, arbitration pointer, warm-up counter and transaction context
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         warm_q  <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 5'd0;
         mode_q  <= 2'b00;
         gnt_q   <= 2'b00;
         s1_q    <= 3'sd0;
      end else begin
         state_q <= state_nxt;
         if (grant) begin
            gnt_q  <= gnt_oh;
            last_q <= pick_ch1;
         end
         if (mode_ld) begin
            mode_q <= mode;
         end
         if (latch_s1) begin
            s1_q <= gen_val;
         end
         if (cnt_load) begin
            cnt_q <= 5'd31;
         end else if (cnt_dec) begin
            cnt_q <= cnt_q - 5'd1;
         end
         if (set_warm) begin
            warm_q <= 1'b1;
         end else if (clr_warm) begin
            warm_q <= 1'b0;
         end
      end
   end

   // registered outputs, decoded from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         ack        <= 2'b00;
         dither_out <= 3'sd0;
         gen_clk_en <= 1'b0;
         gen_rstn   <= 1'b0;
      end else begin
         ack        <= (state_nxt == DONE) ? gnt_oh : 2'b00;
         dither_out <= (state_nxt == DONE) ? load_val : 3'sd0;
         gen_clk_en <= (state_nxt == WARMUP) || (state_nxt == STEP1) ||
                       (state_nxt == STEP2);
         gen_rstn   <= (state_nxt != RSTGEN);
      end
   end

endmodule

// File: tb/tb_dither_ctrl.sv
// Self-checking bench for dither_ctrl: behavioural +/-1 LFSR generator,
// scoreboard of expected acks (channel, value, cycle).
module tb_dither_ctrl;

   localparam logic [15:0] SEED = 16'hACE1;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [1:0]        mode;
   logic [1:0]        req;
   logic [1:0]        ack;
   logic signed [2:0] dither_out;
   logic              gen_clk_en;
   logic              gen_rstn;
   logic [1:0]        gen_dither;
   logic              busy;

   logic [15:0]       g_lfsr;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int strobes = 0;
   int idle_nz = 0;
   int idx = 0;

   typedef struct {
      logic [1:0]        a;
      logic signed [2:0] d;
      int                t;
   } exp_t;

   exp_t sb[$];

   dither_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .req        (req),
      .ack        (ack),
      .dither_out (dither_out),
      .gen_clk_en (gen_clk_en),
      .gen_rstn   (gen_rstn),
      .gen_dither (gen_dither),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_nx(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   // generator output after n steps from its reset
   function automatic logic signed [2:0] gv(input int n);
      logic [15:0] x;
      x = SEED;
      for (int i = 0; i < n; i++) x = lfsr_nx(x);
      return x[0] ? 3'sd1 : -3'sd1;
   endfunction

   // behavioural sequence generator driven by the DUT strobes
   always @(posedge clk) begin
      if (!gen_rstn) g_lfsr <= SEED;
      else if (gen_clk_en) g_lfsr <= lfsr_nx(g_lfsr);
   end
   assign gen_dither = g_lfsr[0] ? 2'b01 : 2'b11;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] a, input logic signed [2:0] d, input int t);
      exp_t e;
      e.a = a;
      e.d = d;
      e.t = t;
      sb.push_back(e);
   endtask

   // monitor: pops one expectation per ack cycle
   always @(negedge clk) begin : mon
      exp_t e;
      if (gen_clk_en) strobes++;
      if (ack != 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", int'(ack), 0);
         end else begin
            e = sb.pop_front();
            chk("ack", int'(ack), int'(e.a));
            chk("dither", int'(dither_out), int'(e.d));
            chk("ack_cycle", cyc, e.t);
         end
      end else if (dither_out != 3'sd0) begin
         idle_nz++;
      end
   end

   task automatic wait_ack(input bit drop);
      bit got;
      int n;
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = (ack != 2'b00);
      end
      chk("ack_seen", int'(got), 1);
      if (drop) req = 2'b00;
   endtask

   task automatic xact(input logic [1:0] r, input logic [1:0] m, input int lat,
                       input logic [1:0] ea, input logic signed [2:0] ed);
      @(posedge clk);
      #1;
      req  = r;
      mode = m;
      push(ea, ed, cyc + lat);
      wait_ack(1'b1);
   endtask

   // watches generator reset and the first strobe run; stops on an ack
   task automatic observe(input int lim, output int rl, output int run, output bit bsy);
      bit ended;
      bit got;
      int n;
      ended = 1'b0;
      got = 1'b0;
      n = 0;
      rl = 0;
      run = 0;
      bsy = 1'b1;
      while (!got && n < lim) begin
         @(negedge clk);
         n++;
         if (!gen_rstn) rl++;
         if (gen_clk_en && !ended) begin
            run++;
            bsy = bsy & busy;
         end else if (run > 0) begin
            ended = 1'b1;
         end
         if (ack != 2'b00) begin
            got = 1'b1;
            req = 2'b00;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int g;
      int k;
      int rl;
      int run;
      bit bsy;

      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'b00;
      req  = 2'b00;

      // reset values
      do_reset();
      @(negedge clk);
      chk("rst_ack", int'(ack), 0);
      chk("rst_dither", int'(dither_out), 0);
      chk("rst_gen_clk_en", int'(gen_clk_en), 0);
      chk("rst_gen_rstn", int'(gen_rstn), 0);
      chk("rst_busy", int'(busy), 0);

      // disabled: answered with zero after one cycle, no generator steps
      s0 = strobes;
      xact(2'b10, 2'b01, 1, 2'b10, 3'sd0);
      chk("off_strobes", strobes - s0, 0);

      // reset with en=1 and ch0 requesting: reset pulse, warm-up, RPDF
      en   = 1'b1;
      req  = 2'b01;
      mode = 2'b01;
      do_reset();
      k = cyc;
      push(2'b01, gv(32), k + 36);
      @(negedge clk);
      observe(50, rl, run, bsy);
      chk("warm_rstn_low", rl, 1);
      chk("warm_run", run, 32);
      chk("warm_busy", int'(bsy), 1);
      idx = 33;

      // single ch1 RPDF; leaves ch1 as last granted
      xact(2'b10, 2'b01, 2, 2'b10, gv(idx));
      idx++;

      // both requesting continuously: ch0,ch1,ch0,ch1
      @(posedge clk);
      #1;
      g    = cyc;
      req  = 2'b11;
      mode = 2'b01;
      for (int i = 0; i < 4; i++)
         push((i % 2 == 0) ? 2'b01 : 2'b10, gv(idx + i), g + 2 + 3 * i);
      for (int i = 0; i < 4; i++) wait_ack(i == 3);
      idx += 4;

      // mode 11 behaves as RPDF
      xact(2'b01, 2'b11, 2, 2'b01, gv(idx));
      idx++;

      // warmed mode 00: zero after one cycle, no steps
      s0 = strobes;
      xact(2'b10, 2'b00, 1, 2'b10, 3'sd0);
      chk("zero_strobes", strobes - s0, 0);

      // 100 back-to-back TPDF on ch0
      s0 = strobes;
      @(posedge clk);
      #1;
      g    = cyc;
      req  = 2'b01;
      mode = 2'b10;
      for (int i = 0; i < 100; i++)
         push(2'b01, gv(idx + 2 * i) + gv(idx + 2 * i + 1), g + 3 + 4 * i);
      for (int i = 0; i < 100; i++) wait_ack(i == 99);
      idx += 200;
      chk("tpdf_strobes", strobes - s0, 200);

      // TPDF with en dropped in STEP1 and mode changed in STEP2
      @(posedge clk);
      #1;
      g    = cyc;
      req  = 2'b01;
      mode = 2'b10;
      push(2'b01, gv(idx) + gv(idx + 1), g + 3);
      @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      mode = 2'b00;
      wait_ack(1'b1);
      idx += 2;
      @(posedge clk);
      s0 = strobes;
      xact(2'b10, 2'b10, 1, 2'b10, 3'sd0);
      chk("after_off_strobes", strobes - s0, 0);

      // re-enable: fresh generator reset and warm-up
      @(posedge clk);
      #1;
      en = 1'b1;
      observe(40, rl, run, bsy);
      chk("rewarm_rstn_low", rl, 1);
      chk("rewarm_run", run, 32);
      idx = 32;
      xact(2'b01, 2'b01, 2, 2'b01, gv(idx));
      idx++;

      // reset during STEP2 aborts without an ack
      @(posedge clk);
      #1;
      req  = 2'b01;
      mode = 2'b10;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ack", int'(ack), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_gen_clk_en", int'(gen_clk_en), 0);
      observe(40, rl, run, bsy);
      chk("abort_rewarm_rstn_low", rl, 1);
      chk("abort_rewarm_run", run, 32);

      chk("sb_empty", sb.size(), 0);
      chk("idle_dither_zero", idle_nz, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
